cla_serial_adder: RTL and testbench
===================================

Name: cla_serial_adder

Overview:
Multi-cycle adder/subtractor that drives the 4-bit carry-lookahead interface. It is the producer side of the g/p-to-carry path: it forms per-bit generate/propagate from its operands, resolves one 4-bit group per clock with lookahead carry equations, and builds the sum from the carries. Operands are NIBBLES*4 bits wide. Valid/ready handshakes on the input and output sides let it sit between datapath stages.

Parameters:
NIBBLES, 4, number of 4-bit groups; operand width W = 4*NIBBLES (default 16).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
in_valid  input  1  operands valid.
in_ready  output  1  block can accept operands.
a  input  W  operand A.
b  input  W  operand B.
cin  input  1  carry-in; ignored when sub=1.
sub  input  1  1: A-B; 0: A+B+cin.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
sum  output  W  result.
cout  output  1  carry out of MSB; for subtract, 1 = no borrow.
ovf  output  1  signed two's-complement overflow.

Behaviour:
- Reset (async, rst=1): state=IDLE, nibble index=0, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0. All operand and carry registers clear.
- IDLE: in_ready=1. On an edge with in_valid=1:
  - latch a and b_eff = sub ? ~b : b;
  - latch carry register c = sub ? 1 : cin;
  - set index=0 and go to CALC.
- CALC: in_ready=0. Each edge processes nibble k=index:
  - per bit: g_i = a_i & b_eff_i; p_i = a_i ^ b_eff_i.
  - C1 = g0|p0&c; C2 = g1|p1&g0|p1&p0&c; C3 and C4 use the same full lookahead expansion (no ripple).
  - sum[4k+3:4k] = p ^ {C3,C2,C1,c}; c <= C4.
  - On the last nibble (index=NIBBLES-1): cout <= C4; ovf <= C4 ^ C3; go to DONE. Otherwise index <= index+1.
- DONE: out_valid=1 and in_ready=0. sum, cout and ovf are held stable while out_valid=1 and out_ready=0.
  - On an edge with out_ready=1: out_valid <= 0, go to IDLE.
  - No new acceptance in the same edge; the next accept is possible one cycle later.
- Latency: accept at edge T; out_valid=1 after edge T+NIBBLES (4 for the default). Throughput is one operation per NIBBLES+2 cycles.
- Inputs a, b, cin and sub may change freely after acceptance; only the latched values are used.
- in_valid while not in IDLE is ignored; the producer holds it, per the valid/ready rule.
- Outputs sum/cout/ovf keep their last result in IDLE until the next completion.
- Reset asserted mid-CALC or mid-DONE: the operation is aborted immediately and all outputs take their reset values. No partial result is ever presented.
- Width: all arithmetic is modulo 2^W. ovf is computed on the MSB only.

Optional Feature:
Macro CLA_GP_OUT_EN.
- Defined: adds outputs grp_g [NIBBLES-1:0] and grp_p [NIBBLES-1:0], one bit per nibble, registered when that nibble is processed.
  - grp_g = g3|p3&g2|p3&p2&g1|p3&p2&p1&g0.
  - grp_p = p0&p1&p2&p3.
  - Both are valid with out_valid, held in DONE, and cleared by reset.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Add, no carry: a=0x1234, b=0x4321, cin=0, sub=0 -> sum=0x5555, cout=0, ovf=0, out_valid exactly 4 cycles after the accept edge.
- Full carry chain: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. With CLA_GP_OUT_EN defined: grp_p=4'b1110, grp_g=4'b0001.
- Signed overflow: a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1. Subtract: a=0x0005, b=0x0007, sub=1, cin=1 (ignored) -> sum=0xFFFE, cout=0, ovf=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> sum/cout/ovf stable, in_ready=0, and a second in_valid is not accepted. Raise out_ready -> out_valid drops next edge and in_ready=1 again.
- Reset mid-op: accept 0x1111+0x2222 and assert rst asynchronously (off-edge) after 2 CALC edges -> outputs zero immediately and in_ready=1. A new request 0x0001+0x0001 then yields sum=0x0002 with no stale state.

Source files
------------

// File: rtl/cla_serial_adder.sv
// -----------------------------------------------------------------------------
// cla_serial_adder
//
// Multi-cycle adder/subtractor built around a 4-bit carry-lookahead slice.
// Operands are latched on acceptance, then one 4-bit group is resolved per
// clock using full lookahead carry equations (no ripple inside a group).
// The group carry-out is carried to the next group through a register.
//
// Parameters:
//   NIBBLES   number of 4-bit groups; operand width W = 4*NIBBLES
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   operands valid            in_ready   block can accept operands
//   a, b       operands (W bits)
//   cin        carry-in (ignored when sub=1)
//   sub        1: a-b, 0: a+b+cin
//   out_valid  result valid              out_ready  consumer accepts result
//   sum        result (W bits)
//   cout       carry out of MSB (for subtract, 1 = no borrow)
//   ovf        signed two's-complement overflow
//
// Optional feature (macro CLA_GP_OUT_EN):
//   grp_g, grp_p  per-group generate/propagate, one bit per nibble,
//                 captured as each nibble is processed and held in DONE.
// -----------------------------------------------------------------------------
module cla_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 cin,
    input  logic                 sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic                 ovf
`ifdef CLA_GP_OUT_EN
    ,
    output logic [NIBBLES-1:0]   grp_g,
    output logic [NIBBLES-1:0]   grp_p
`endif
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [IDX_W-1:0]   r_idx;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;        // already inverted for subtract
    logic               r_c;        // carry into the current group
    logic [W-1:0]       r_acc;      // partial sum, never exposed
    logic [W-1:0]       r_sum;
    logic               r_cout;
    logic               r_ovf;
    logic               r_in_ready;
    logic               r_out_valid;
`ifdef CLA_GP_OUT_EN
    logic [NIBBLES-1:0] r_grp_g;
    logic [NIBBLES-1:0] r_grp_p;
`endif

    logic [IDX_W+1:0]   w_bit_base;
    logic [3:0]         w_a_nib;
    logic [3:0]         w_b_nib;
    logic [3:0]         w_g;
    logic [3:0]         w_p;
    logic               w_c1;
    logic               w_c2;
    logic               w_c3;
    logic               w_c4;
    logic [3:0]         w_sum_nib;
    logic [W-1:0]       w_acc_next;
    logic               w_last;
    logic               w_grp_g;
    logic               w_grp_p;

    assign w_bit_base = {r_idx, 2'b00};
    assign w_last     = (r_idx == IDX_LAST);

    // Lookahead slice for the group selected by r_idx.
    always_comb begin
        w_a_nib   = r_a[w_bit_base +: 4];
        w_b_nib   = r_b[w_bit_base +: 4];
        w_g       = w_a_nib & w_b_nib;
        w_p       = w_a_nib ^ w_b_nib;
        w_c1      = w_g[0] | (w_p[0] & r_c);
        w_c2      = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_c);
        w_c3      = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & r_c);
        w_grp_g   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
        w_grp_p   = w_p[0] & w_p[1] & w_p[2] & w_p[3];
        w_c4      = w_grp_g | (w_grp_p & r_c);
        w_sum_nib = w_p ^ {w_c3, w_c2, w_c1, r_c};
        w_acc_next = r_acc;
        w_acc_next[w_bit_base +: 4] = w_sum_nib;
    end

    // Next-state logic for the IDLE -> CALC -> DONE sequence.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_next = S_CALC;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_CALC: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_CALC;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_DONE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State, operand, carry and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_c         <= 1'b0;
            r_acc       <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
`ifdef CLA_GP_OUT_EN
            r_grp_g     <= '0;
            r_grp_p     <= '0;
`endif
        end else begin
            r_state     <= w_state_next;
            // Handshake flags follow the next state so they are glitch-free.
            r_in_ready  <= (w_state_next == S_IDLE);
            r_out_valid <= (w_state_next == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a   <= a;
                        r_b   <= sub ? ~b : b;
                        // Subtract is a + ~b + 1, so the carry-in is forced.
                        r_c   <= sub ? 1'b1 : cin;
                        r_idx <= '0;
                        r_acc <= '0;
                    end
                end
                S_CALC: begin
                    r_acc <= w_acc_next;
                    r_c   <= w_c4;
`ifdef CLA_GP_OUT_EN
                    r_grp_g[r_idx] <= w_grp_g;
                    r_grp_p[r_idx] <= w_grp_p;
`endif
                    if (w_last) begin
                        // Only a complete result is ever published.
                        r_sum  <= w_acc_next;
                        r_cout <= w_c4;
                        r_ovf  <= w_c4 ^ w_c3;
                    end else begin
                        r_idx  <= r_idx + IDX_W'(1);
                    end
                end
                S_DONE: begin
                    r_idx <= r_idx;
                end
                default: begin
                    r_idx <= '0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
`ifdef CLA_GP_OUT_EN
    assign grp_g     = r_grp_g;
    assign grp_p     = r_grp_p;
`endif

endmodule

// File: tb/tb_cla_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_cla_serial_adder
//
// Directed testbench for cla_serial_adder (NIBBLES=4, W=16). Expected values
// are hand-computed constants. Optional group g/p outputs are checked when
// CLA_GP_OUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_cla_serial_adder;

    localparam int NIBBLES = 4;
    localparam int W       = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
`ifdef CLA_GP_OUT_EN
    logic [NIBBLES-1:0] grp_g;
    logic [NIBBLES-1:0] grp_p;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    cla_serial_adder #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_in),
        .b         (b_in),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
`ifdef CLA_GP_OUT_EN
        ,
        .grp_g     (grp_g),
        .grp_p     (grp_p)
`endif
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one operation at a negedge; returns just after the accept edge.
    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic ci, input logic sb);
        @(negedge clk);
        check_val("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        a_in     = av;
        b_in     = bv;
        cin      = ci;
        sub      = sb;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Scramble inputs: only the latched copies may be used.
        a_in = ~av;
        b_in = ~bv;
        cin  = ~ci;
        sub  = ~sb;
    endtask

    // Count edges after acceptance until out_valid, bounded.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_val("out_valid_drop", {31'd0, out_valid}, 32'd0);
        check_val("in_ready_back", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run_case(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic ci, input logic sb, input logic [W-1:0] es,
                            input logic ec, input logic eo);
        int cyc;
        start_op(av, bv, ci, sb);
        wait_done(cyc);
        check_val({tag, "_latency"}, cyc, 32'd4);
        check_val({tag, "_sum"}, {16'd0, sum}, {16'd0, es});
        check_val({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
        check_val({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a_in      = 16'h0000;
        b_in      = 16'h0000;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b0;
        #12;
        check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_sum", {16'd0, sum}, 32'd0);
        check_val("rst_cout", {31'd0, cout}, 32'd0);
        check_val("rst_ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_case("add_nocarry", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        release_out();

        run_case("carry_chain", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
`ifdef CLA_GP_OUT_EN
        check_val("carry_chain_grp_p", {28'd0, grp_p}, 32'h0000000E);
        check_val("carry_chain_grp_g", {28'd0, grp_g}, 32'h00000001);
`endif
        release_out();

        run_case("add_cin", 16'h0F0F, 16'h00F0, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);
        release_out();

        // Signed overflow, then hold the result under backpressure.
        run_case("sovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a_in     = 16'h0101 * i[15:0];
            b_in     = 16'h3333;
            cin      = 1'b1;
            sub      = 1'b0;
            check_val("bp_sum", {16'd0, sum}, 32'h00008000);
            check_val("bp_cout", {31'd0, cout}, 32'd0);
            check_val("bp_ovf", {31'd0, ovf}, 32'd1);
            check_val("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check_val("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        release_out();
        // The in_valid held during DONE must not have started anything.
        repeat (6) @(posedge clk);
        #1;
        check_val("bp_no_accept_valid", {31'd0, out_valid}, 32'd0);
        check_val("bp_no_accept_sum", {16'd0, sum}, 32'h00008000);

        run_case("sub", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        release_out();

        // Reset after two CALC edges, asserted off-edge.
        start_op(16'h1111, 16'h2222, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_val("midrst_sum", {16'd0, sum}, 32'd0);
        check_val("midrst_cout", {31'd0, cout}, 32'd0);
        check_val("midrst_ovf", {31'd0, ovf}, 32'd0);
        check_val("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("midrst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef CLA_GP_OUT_EN
        check_val("midrst_grp_g", {28'd0, grp_g}, 32'd0);
        check_val("midrst_grp_p", {28'd0, grp_p}, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        run_case("after_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);
        release_out();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
